// File: rtl/mips_fetch_stage.sv
// MIPS-Lite instruction fetch: program counter, imem addressing and the IF/ID register.
// Defining FETCH_PERF_CNT_EN adds the fetch_count port and its saturating counter.
module mips_fetch_stage #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt_retired,
   output logic [31:0]       ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc,
   output logic              ifid_valid,
   output logic              halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_count
`endif
);

   localparam logic [5:0] OP_HALT = 6'h11;

   typedef enum logic [1:0] {
      RUN,
      HALT_PEND,
      HALTED
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] pc_p0;
   logic [ADDR_W-1:0] pc_nxt;
   logic [31:0]       instr_nxt;
   logic [ADDR_W-1:0] ipc_nxt;
   logic              vld_nxt;

   assign imem_addr = pc_p0;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Priority: HALTED is terminal, then redirect, then stall, then the state action
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_p0;
      instr_nxt = ifid_instr;
      ipc_nxt   = ifid_pc;
      vld_nxt   = ifid_valid;
      if (state == HALTED) begin
         vld_nxt = 1'b0;
      end else if (redirect_valid) begin
         pc_nxt    = redirect_pc & ~ADDR_W'(3);
         instr_nxt = 32'h0;
         ipc_nxt   = '0;
         vld_nxt   = 1'b0;
         state_nxt = RUN;
      end else if (!stall) begin
         case (state)
            RUN: begin
               instr_nxt = imem_rdata;
               ipc_nxt   = pc_p0;
               vld_nxt   = 1'b1;
               if (imem_rdata[31:26] == OP_HALT) begin
                  state_nxt = HALT_PEND;
               end else begin
                  pc_nxt = pc_p0 + ADDR_W'(4);
               end
            end
            HALT_PEND: begin
               instr_nxt = 32'h0;
               ipc_nxt   = '0;
               vld_nxt   = 1'b0;
               if (halt_retired) begin
                  state_nxt = HALTED;
               end
            end
            default: begin
               state_nxt = RUN;
            end
         endcase
      end
   end

   // PC and IF/ID register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_p0      <= RESET_PC;
         ifid_instr <= 32'h0;
         ifid_pc    <= '0;
         ifid_valid <= 1'b0;
         halted     <= 1'b0;
      end else begin
         pc_p0      <= pc_nxt;
         ifid_instr <= instr_nxt;
         ifid_pc    <= ipc_nxt;
         ifid_valid <= vld_nxt;
         halted     <= (state_nxt == HALTED);
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic fetch_load;

   // Only a real RUN-state fetch loads a valid instruction; bubbles and holds do not count
   assign fetch_load = (state == RUN) && !redirect_valid && !stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= 32'h0;
      end else if (fetch_load && (fetch_count != 32'hFFFF_FFFF)) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule
